// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one bit of a+b per clock through a one-bit carry register.
// The bit cell is two half adders plus an OR on their carries.

module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0] ps_q, ps_d, sum_q, sum_d;
    logic             c_q, c_d, carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             hs, hc0, s_bit, hc1, c_next;
    logic [WIDTH-1:0] ps_shift;

    half_adder u_ha0 (.a(sa_q[0]), .b(sb_q[0]), .sum(hs),    .carry(hc0));
    half_adder u_ha1 (.a(hs),      .b(c_q),     .sum(s_bit), .carry(hc1));

    assign c_next = hc0 | hc1;

    // New sum bit enters at the MSB so the LSB-first stream ends up in place.
    assign ps_shift = (ps_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ps_d    = ps_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        busy    = (state_q == SHIFT);
        done    = (state_q == DONE);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    sa_d    = a;
                    sb_d    = b;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    ps_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                c_d   = c_next;
                ps_d  = ps_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    sum_d   = ps_shift;
                    carry_d = c_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            ps_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ps_q    <= ps_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit and a 4-bit instance checked every cycle against
// a latency/arithmetic model, plus literal results for hand-worked cases.

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8, busy8, done8, carry8;
    logic [7:0] a8, b8, sum8;
    logic       start4, busy4, done4, carry4;
    logic [3:0] a4, b4, sum4;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .carry(carry4)
    );

    // Model: an accepted operation finishes exactly WIDTH edges later with result a+b.
    int          rem[2];
    logic [32:0] pend[2];
    logic [32:0] eres[2];
    bit          edone[2];
    bit          m_st;
    logic [31:0] m_a, m_b;
    int          m_w;

    initial begin
        for (int k = 0; k < 2; k++) begin
            rem[k]   = 0;
            pend[k]  = '0;
            eres[k]  = '0;
            edone[k] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_w  = (k == 0) ? 8 : 4;
            m_st = (k == 0) ? start8 : start4;
            m_a  = (k == 0) ? 32'(a8) : 32'(a4);
            m_b  = (k == 0) ? 32'(b8) : 32'(b4);
            if (rst) begin
                rem[k]   = 0;
                edone[k] = 1'b0;
                eres[k]  = '0;
            end else begin
                edone[k] = 1'b0;
                if (rem[k] > 0) begin
                    rem[k] = rem[k] - 1;
                    if (rem[k] == 0) begin
                        edone[k] = 1'b1;
                        eres[k]  = pend[k];
                    end
                end else if (m_st) begin
                    pend[k] = 33'(m_a) + 33'(m_b);
                    rem[k]  = m_w;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [32:0] act, input logic [32:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            checkOutput("busy8",  33'(busy8),  33'(rem[0] > 0));
            checkOutput("done8",  33'(done8),  33'(edone[0]));
            checkOutput("sum8",   33'(sum8),   33'(eres[0][7:0]));
            checkOutput("carry8", 33'(carry8), 33'(eres[0][8]));
            checkOutput("busy4",  33'(busy4),  33'(rem[1] > 0));
            checkOutput("done4",  33'(done4),  33'(edone[1]));
            checkOutput("sum4",   33'(sum4),   33'(eres[1][3:0]));
            checkOutput("carry4", 33'(carry4), 33'(eres[1][4]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input logic st, input logic [7:0] av, input logic [7:0] bv);
        start8 = st;
        a8     = av;
        b8     = bv;
        step();
    endtask

    task automatic runOp8(input string name, input logic [7:0] av, input logic [7:0] bv,
                          input logic [8:0] expv);
        int busyCnt;
        bit got;
        busyCnt = 0;
        got     = 1'b0;
        applyStimulus(1'b1, av, bv);
        start8 = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (done8) got = 1'b1;
            else begin
                if (busy8) busyCnt++;
                step();
            end
        end
        if (!got) checkOutput({name, "_timeout"}, 33'(0), 33'(1));
        checkOutput(name, 33'({carry8, sum8}), 33'(expv));
        checkOutput({name, "_busycycles"}, 33'(busyCnt), 33'(8));
    endtask

    initial begin
        int  dones;
        int  lastDone;
        bit  got;
        logic [8:0] seen;

        rst    = 1'b1;
        start8 = 1'b1;
        a8     = 8'hFF;
        b8     = 8'h01;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        step();
        step();
        checkOutput("reset_result", 33'({carry8, sum8}), 33'(0));
        checkOutput("reset_busy",   33'(busy8), 33'(0));
        checkOutput("reset_done",   33'(done8), 33'(0));
        rst    = 1'b0;
        start8 = 1'b0;
        step();
        step();
        checkOutput("idle_after_reset", 33'(busy8), 33'(0));

        runOp8("basic", 8'h5A, 8'h33, 9'h08D);
        step();
        checkOutput("basic_done_pulse", 33'(done8), 33'(0));
        step();
        step();
        checkOutput("basic_hold", 33'({carry8, sum8}), 33'(9'h08D));

        runOp8("ff_01", 8'hFF, 8'h01, 9'h100);
        runOp8("ff_ff", 8'hFF, 8'hFF, 9'h1FE);

        applyStimulus(1'b1, 8'h10, 8'h20);
        applyStimulus(1'b0, 8'h10, 8'h20);
        applyStimulus(1'b1, 8'hAA, 8'h55);
        start8 = 1'b0;
        dones  = 0;
        seen   = '0;
        for (int i = 0; i < 24; i++) begin
            if (done8) begin
                dones++;
                seen = {carry8, sum8};
            end
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            step();
        end
        checkOutput("ignore_done_count", 33'(dones), 33'(1));
        checkOutput("ignore_result", 33'(seen), 33'(9'h030));

        applyStimulus(1'b1, 8'h7F, 8'h7F);
        applyStimulus(1'b0, 8'h00, 8'h00);
        applyStimulus(1'b0, 8'h00, 8'h00);
        applyStimulus(1'b0, 8'h00, 8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("abort_busy",   33'(busy8), 33'(0));
        checkOutput("abort_result", 33'({carry8, sum8}), 33'(0));
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) dones++;
            step();
        end
        checkOutput("abort_no_done", 33'(dones), 33'(0));
        runOp8("after_abort", 8'h01, 8'h02, 9'h003);

        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 60) == 0);
            start8 = ($urandom_range(0, 2) == 0);
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            step();
        end
        rst    = 1'b0;
        start8 = 1'b0;
        step();

        start4   = 1'b1;
        lastDone = 0;
        for (int p = 0; p < 256; p++) begin
            a4  = 4'(p >> 4);
            b4  = 4'(p & 15);
            got = 1'b0;
            for (int i = 0; i < 12 && !got; i++) begin
                step();
                if (done4) got = 1'b1;
            end
            if (!got) checkOutput("exh4_timeout", 33'(0), 33'(1));
            else begin
                if (p > 0) checkOutput("exh4_spacing", 33'(cyc - lastDone), 33'(5));
                lastDone = cyc;
                checkOutput("exh4_result", 33'({carry4, sum4}), 33'((p >> 4) + (p & 15)));
            end
        end
        start4 = 1'b0;
        for (int i = 0; i < 8; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
